input_sample_streamer: RTL and testbench

//  Avalon-MM slave that holds FIR input samples loaded by the processor and streams them into the

---
 rtl/input_sample_streamer_pkg.sv | 43 ++++
 rtl/input_sample_streamer_dpram.sv | 40 ++++
 rtl/input_sample_streamer.sv | 215 +++++++++++++++++++++
 tb/tb_input_sample_streamer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_sample_streamer_pkg.sv
// Address map, CSR layout and shared types for the FIR input sample streamer.
package input_sample_streamer_pkg;

    // Avalon word-address map shared with the rest of the FIR subsystem.
    localparam int unsigned MapMemBase = 8192;
    localparam int unsigned MapCsrBase = 10240;
    localparam int unsigned MapCapBase = 12288;  // output capture window (owned elsewhere)

    // CSR word offsets from MapCsrBase.
    localparam logic [1:0] OffCtrl   = 2'd0;
    localparam logic [1:0] OffLen    = 2'd1;
    localparam logic [1:0] OffDiv    = 2'd2;
    localparam logic [1:0] OffStatus = 2'd3;

    // CTRL bit positions.
    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlAbortBit = 1;
    localparam int unsigned CtrlLoopBit  = 2;

    localparam int unsigned LenW   = 11;
    localparam int unsigned CountW = 13;
    localparam logic [CountW-1:0] CountMax = '1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Which source drives readdata in the cycle after a read.
    typedef enum logic [1:0] {
        RdNone = 2'd0,
        RdMem  = 2'd1,
        RdCsr  = 2'd2
    } rd_sel_e;

    // STATUS layout: {count, reserved 0, done, busy}.
    function automatic logic [15:0] status_word(input logic [CountW-1:0] count,
                                                input logic done_f, input logic busy_f);
        return {count, 1'b0, done_f, busy_f};
    endfunction

endpackage

// File: rtl/input_sample_streamer_dpram.sv
// Sample memory: port A is the Avalon read/write side, port B the streamer read side.
// Both ports have one cycle of registered read latency; no reset so it maps onto block RAM.
module input_sample_streamer_dpram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              a_we_i,
    input  logic [AW-1:0]     a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_re_i,
    input  logic [AW-1:0]     b_addr_i,
    output logic [DATA_W-1:0] b_rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Port A: processor write plus read-first registered readback.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        a_rdata_q <= mem_q[a_addr_i];
    end

    // Port B: streamer fetch, output holds when no fetch is issued.
    always_ff @(posedge clk_i) begin
        if (b_re_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/input_sample_streamer.sv
// Avalon-MM slave holding FIR input samples and streaming them out at a programmable rate.
// Holds the Avalon decode, CSRs, the IDLE/RUN/DONE sequencer, rate divider and read pointer.
module input_sample_streamer
    import input_sample_streamer_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned MEM_BASE = MapMemBase,
    parameter int unsigned CSR_BASE = MapCsrBase
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Address decode.
    logic [31:0]   addr_w;
    logic          mem_hit;
    logic          csr_hit;
    logic [1:0]    csr_off;
    logic [AW-1:0] mem_idx;

    assign addr_w  = 32'(address);
    assign mem_hit = (addr_w >= MEM_BASE) && (addr_w < MEM_BASE + DEPTH);
    assign csr_hit = (addr_w >= CSR_BASE) && (addr_w < CSR_BASE + 4);
    assign csr_off = 2'(addr_w - CSR_BASE);
    assign mem_idx = AW'(addr_w - MEM_BASE);

    logic ctrl_wr;
    logic start_req;
    logic abort_req;

    assign ctrl_wr   = write && csr_hit && (csr_off == OffCtrl);
    assign start_req = ctrl_wr && writedata[CtrlStartBit];
    assign abort_req = ctrl_wr && writedata[CtrlAbortBit];

    // Sequencer state.
    state_e              state_q, state_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CountW-1:0]   count_q, count_d;
    logic                loop_q, loop_d;
    logic                issue;

    // CSRs.
    logic [LenW-1:0]     len_q;
    logic [DATA_W-1:0]   div_q;
    logic [AW-1:0]       len_last;

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign len_last = AW'(len_q - LenW'(1));

    // Next-state logic: abort has priority, start only honoured outside RUN.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        div_cnt_d = div_cnt_q;
        count_d   = count_q;
        loop_d    = loop_q;
        issue     = 1'b0;
        if (abort_req) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_req) begin
                        loop_d    = writedata[CtrlLoopBit];
                        rd_ptr_d  = '0;
                        div_cnt_d = '0;
                        count_d   = '0;
                        state_d   = (len_q == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (div_cnt_q == '0) begin
                        issue     = 1'b1;
                        div_cnt_d = div_q;
                        count_d   = (count_q == CountMax) ? count_q : count_q + 1'b1;
                        if (rd_ptr_q == len_last) begin
                            rd_ptr_d = '0;
                            if (!loop_q) begin
                                state_d = StDone;
                            end
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rd_ptr_q  <= '0;
            div_cnt_q <= '0;
            count_q   <= '0;
            loop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            div_cnt_q <= div_cnt_d;
            count_q   <= count_d;
            loop_q    <= loop_d;
        end
    end

    // LEN/DIV are frozen while a pass is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
            div_q <= '0;
        end else if (write && csr_hit && !busy) begin
            if (csr_off == OffLen) begin
                len_q <= writedata[LenW-1:0];
            end
            if (csr_off == OffDiv) begin
                div_q <= writedata;
            end
        end
    end

    // Sample memory.
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] strm_rdata;

    input_sample_streamer_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_dpram (
        .clk_i     (clk),
        .a_we_i    (write && mem_hit && !busy),
        .a_addr_i  (mem_idx),
        .a_wdata_i (writedata),
        .a_rdata_o (mem_rdata),
        .b_re_i    (issue),
        .b_addr_i  (rd_ptr_q),
        .b_rdata_o (strm_rdata)
    );

    // CSR readback value captured alongside the read strobe.
    logic [DATA_W-1:0] csr_rdata_d;
    logic [DATA_W-1:0] csr_rdata_q;
    rd_sel_e           rd_sel_q;

    // CSR read mux; CTRL is write-only and reads as zero.
    always_comb begin
        csr_rdata_d = '0;
        unique case (csr_off)
            OffLen:    csr_rdata_d = DATA_W'(len_q);
            OffDiv:    csr_rdata_d = div_q;
            OffStatus: csr_rdata_d = DATA_W'(status_word(count_q, done, busy));
            default:   csr_rdata_d = '0;
        endcase
    end

    // Read path: remember the source so readdata is valid exactly one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sel_q    <= RdNone;
            csr_rdata_q <= '0;
        end else begin
            rd_sel_q    <= RdNone;
            csr_rdata_q <= '0;
            if (read && mem_hit) begin
                rd_sel_q <= RdMem;
            end else if (read && csr_hit) begin
                rd_sel_q    <= RdCsr;
                csr_rdata_q <= csr_rdata_d;
            end
        end
    end

    assign readdata = (rd_sel_q == RdMem) ? mem_rdata   :
                      (rd_sel_q == RdCsr) ? csr_rdata_q : '0;

    // Strobe follows an issued fetch by one cycle; the held copy keeps sample_out stable.
    logic              valid_q;
    logic [DATA_W-1:0] hold_q;

    // Strobe and sample hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            valid_q <= issue;
            if (valid_q) begin
                hold_q <= strm_rdata;
            end
        end
    end

    assign sample_valid = valid_q;
    assign sample_out   = valid_q ? strm_rdata : hold_q;

endmodule

// File: tb/tb_input_sample_streamer.sv
// Self-checking bench for input_sample_streamer: table-driven Avalon vectors, directed
// multi-cycle sequences and randomized single passes checked against an arithmetic model.
module tb_input_sample_streamer;

    localparam int unsigned MEM = 8192;
    localparam int unsigned CSR = 10240;
    localparam int unsigned CAP = 12288;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        done;

    input_sample_streamer dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .write        (write),
        .writedata    (writedata),
        .read         (read),
        .readdata     (readdata),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log: value and cycle of every sample_valid, sampled mid-cycle.
    logic [15:0] sv_q[$];
    int          sc_q[$];
    always @(negedge clk) begin
        if (sample_valid) begin
            sv_q.push_back(sample_out);
            sc_q.push_back(cyc);
        end
    end

    int checks = 0;
    int errors = 0;
    int last_wcyc = 0;

    typedef struct {
        logic        wr;
        logic [17:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl[17];
    logic [15:0] img[2048];
    logic [15:0] seq4[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // STATUS word as the register map defines it.
    function automatic logic [31:0] exp_status(input int count, input int d, input int b);
        return 32'(((count % 8192) * 8 + d * 2 + b) % 65536);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input int addr, input int data);
        address   = 18'(addr);
        writedata = 16'(data);
        write     = 1'b1;
        last_wcyc = cyc;
        tick();
        write   = 1'b0;
        address = '0;
    endtask

    task automatic av_read(input int addr, output logic [15:0] data);
        address = 18'(addr);
        read    = 1'b1;
        tick();
        read    = 1'b0;
        address = '0;
        data    = readdata;
    endtask

    task automatic clear_log();
        sv_q.delete();
        sc_q.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        if (!done) check({name, " done timeout"}, 32'(done), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_strobes(input string name, input int n, input int budget);
        for (int i = 0; i < budget && sv_q.size() < n; i++) tick();
        if (sv_q.size() < n) check({name, " strobe timeout"}, 32'(sv_q.size()), 32'(n));
    endtask

    logic [15:0] rd;
    int          w;
    int          n;
    int          len;
    int          dv;
    int          bad;

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset valid", 32'(sample_valid), 0);
        check("reset sample_out", 32'(sample_out), 0);
        check("reset readdata", 32'(readdata), 0);

        // Load / readback / CSR access vectors.
        tbl[0]  = '{1'b1, 18'(MEM + 0), 16'h0001, 16'h0000, "wr mem0"};
        tbl[1]  = '{1'b1, 18'(MEM + 1), 16'h0002, 16'h0000, "wr mem1"};
        tbl[2]  = '{1'b1, 18'(MEM + 2), 16'h7FFF, 16'h0000, "wr mem2"};
        tbl[3]  = '{1'b1, 18'(MEM + 3), 16'h8000, 16'h0000, "wr mem3"};
        tbl[4]  = '{1'b0, 18'(MEM + 0), 16'h0000, 16'h0001, "rd mem0"};
        tbl[5]  = '{1'b0, 18'(MEM + 1), 16'h0000, 16'h0002, "rd mem1"};
        tbl[6]  = '{1'b0, 18'(MEM + 2), 16'h0000, 16'h7FFF, "rd mem2"};
        tbl[7]  = '{1'b0, 18'(MEM + 3), 16'h0000, 16'h8000, "rd mem3"};
        tbl[8]  = '{1'b0, 18'(CAP), 16'h0000, 16'h0000, "rd capture base"};
        tbl[9]  = '{1'b0, 18'(MEM - 1), 16'h0000, 16'h0000, "rd below mem"};
        tbl[10] = '{1'b1, 18'(CSR + 1), 16'h0004, 16'h0000, "wr len"};
        tbl[11] = '{1'b0, 18'(CSR + 1), 16'h0000, 16'h0004, "rd len"};
        tbl[12] = '{1'b1, 18'(CSR + 2), 16'h0007, 16'h0000, "wr div"};
        tbl[13] = '{1'b0, 18'(CSR + 2), 16'h0000, 16'h0007, "rd div"};
        tbl[14] = '{1'b1, 18'(CSR + 2), 16'h0000, 16'h0000, "wr div0"};
        tbl[15] = '{1'b0, 18'(CSR + 0), 16'h0000, 16'h0000, "rd ctrl"};
        tbl[16] = '{1'b0, 18'(CSR + 4), 16'h0000, 16'h0000, "rd past csr"};
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) begin
                av_write(int'(tbl[i].addr), int'(tbl[i].data));
            end else begin
                av_read(int'(tbl[i].addr), rd);
                check(tbl[i].name, 32'(rd), 32'(tbl[i].exp));
            end
        end
        av_read(CSR + 3, rd);
        check("status idle", 32'(rd), exp_status(0, 0, 0));

        // Single pass: LEN=4, DIV=0.
        seq4[0] = 16'h0001;
        seq4[1] = 16'h0002;
        seq4[2] = 16'h7FFF;
        clear_log();
        av_write(CSR + 0, 1);
        w = last_wcyc;
        wait_done("single", 30);
        check("single count", 32'(sv_q.size()), 4);
        for (int k = 0; k < 4 && k < sv_q.size(); k++) begin
            check($sformatf("single val%0d", k), 32'(sv_q[k]),
                  (k < 3) ? 32'(seq4[k]) : 32'h8000);
            check($sformatf("single cyc%0d", k), 32'(sc_q[k] - w), 32'(2 + k));
        end
        check("single done", 32'(done), 1);
        check("single hold", 32'(sample_out), 32'h8000);
        av_read(CSR + 3, rd);
        check("single status", 32'(rd), exp_status(4, 1, 0));

        // Reset asserted mid-RUN.
        av_write(CSR + 2, 2);
        av_write(CSR + 0, 5);
        clear_log();
        wait_strobes("reset run", 3, 40);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("midrun reset busy", 32'(busy), 0);
        check("midrun reset valid", 32'(sample_valid), 0);
        n = sv_q.size();
        repeat (10) tick();
        check("midrun no strobes", 32'(sv_q.size()), 32'(n));
        av_read(CSR + 3, rd);
        check("midrun status", 32'(rd), 0);
        av_read(MEM + 2, rd);
        check("midrun mem2", 32'(rd), 32'h7FFF);
        av_read(MEM + 3, rd);
        check("midrun mem3", 32'(rd), 32'h8000);

        // Rate and loop: LEN=3, DIV=4, abort after 7 strobes.
        av_write(CSR + 1, 3);
        av_write(CSR + 2, 4);
        clear_log();
        av_write(CSR + 0, 5);
        w = last_wcyc;
        wait_strobes("loop", 7, 60);
        av_write(CSR + 0, 2);
        repeat (20) tick();
        check("loop strobe count", 32'(sv_q.size()), 7);
        bad = 0;
        for (int k = 0; k < sv_q.size(); k++) begin
            if (sv_q[k] !== seq4[k % 3]) bad++;
            if (sc_q[k] != w + 2 + 5 * k) bad++;
        end
        check("loop sequence/spacing", 32'(bad), 0);
        check("loop abort busy", 32'(busy), 0);
        check("loop abort done", 32'(done), 0);

        // LEN=0: straight to DONE, no strobes.
        av_write(CSR + 1, 0);
        clear_log();
        av_write(CSR + 0, 1);
        check("len0 done", 32'(done), 1);
        repeat (10) tick();
        check("len0 strobes", 32'(sv_q.size()), 0);

        // Writes during RUN are ignored.
        av_write(CSR + 1, 3);
        clear_log();
        av_write(CSR + 0, 1);
        w = last_wcyc;
        tick();
        av_write(MEM + 0, 16'h1234);
        av_write(CSR + 1, 7);
        av_write(CSR + 2, 9);
        wait_done("frozen", 40);
        check("frozen count", 32'(sv_q.size()), 3);
        if (sv_q.size() == 3) begin
            check("frozen first", 32'(sv_q[0]), 32'h0001);
            check("frozen last cyc", 32'(sc_q[2] - w), 32'(2 + 10));
        end
        av_read(CSR + 1, rd);
        check("frozen len", 32'(rd), 3);
        av_read(CSR + 2, rd);
        check("frozen div", 32'(rd), 4);
        av_read(MEM + 0, rd);
        check("frozen mem0", 32'(rd), 1);

        // Start and abort together from IDLE.
        av_write(CSR + 0, 2);
        clear_log();
        av_write(CSR + 0, 3);
        check("start+abort busy", 32'(busy), 0);
        check("start+abort done", 32'(done), 0);
        repeat (10) tick();
        check("start+abort strobes", 32'(sv_q.size()), 0);

        // Randomized single passes against the arithmetic model.
        for (int it = 0; it < 6; it++) begin
            len = int'($urandom_range(1, 12));
            dv  = int'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                img[i] = 16'($urandom);
                av_write(MEM + i, int'(img[i]));
            end
            av_write(CSR + 1, len);
            av_write(CSR + 2, dv);
            clear_log();
            av_write(CSR + 0, 1);
            w = last_wcyc;
            wait_done("rand", len * (dv + 1) + 20);
            check($sformatf("rand%0d count", it), 32'(sv_q.size()), 32'(len));
            bad = 0;
            for (int k = 0; k < sv_q.size() && k < len; k++) begin
                if (sv_q[k] !== img[k]) bad++;
                if (sc_q[k] != w + 2 + k * (dv + 1)) bad++;
            end
            check($sformatf("rand%0d seq", it), 32'(bad), 0);
            av_read(CSR + 3, rd);
            check($sformatf("rand%0d status", it), 32'(rd), exp_status(len, 1, 0));
        end

        // Full depth: LEN=2047, DIV=0, mem[i]=i.
        for (int i = 0; i < 2047; i++) av_write(MEM + i, i);
        av_write(CSR + 1, 2047);
        av_write(CSR + 2, 0);
        clear_log();
        av_write(CSR + 0, 1);
        w = last_wcyc;
        wait_done("full", 2100);
        check("full count", 32'(sv_q.size()), 2047);
        bad = 0;
        for (int k = 0; k < sv_q.size(); k++) begin
            if (sv_q[k] !== 16'(k)) bad++;
            if (sc_q[k] != w + 2 + k) bad++;
        end
        check("full seq", 32'(bad), 0);
        check("full done", 32'(done), 1);
        av_read(CSR + 3, rd);
        check("full status", 32'(rd), exp_status(2047, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
